// File: rtl/topk_stream_sorter.sv
// ---------------------------------------------------------------------------
// topk_stream_sorter
//
// Streaming top-K selector. Candidates (distance, address) arrive one per
// cycle and are inserted into a sorted bank of K slots (slot 0 = nearest).
// Ordering is lexicographic on (dist, addr); an identical pair lands behind
// the entry already stored. After the candidate flagged in_last, the bank is
// drained in ascending order, one winner per out handshake, then the block
// re-arms for the next batch.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds its payload until the transfer. The block presents
// out_* from registers only and holds them while out_valid && !out_ready.
//
// Optional feature macro: TOPK_STATS_EN adds the seen_cnt output, a
// saturating count of accepted candidates in the current batch.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   candidate present
//   in_ready   out  block accepts a candidate (high in COLLECT)
//   in_dist    in   candidate distance, unsigned
//   in_addr    in   candidate address
//   in_last    in   final candidate of the batch
//   out_valid  out  winner present (DRAIN only)
//   out_ready  in   consumer accepts the winner
//   out_dist   out  winner distance
//   out_addr   out  winner address
//   out_rank   out  winner rank, 0 = nearest
//   out_last   out  final winner of the batch
//   seen_cnt   out  accepted-candidate count (TOPK_STATS_EN only)
// ---------------------------------------------------------------------------
module topk_stream_sorter #(
   parameter  int DIST_W = 12,
   parameter  int ADDR_W = 3,
   parameter  int K      = 4,
   localparam int RANK_W = (K > 1) ? $clog2(K) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIST_W-1:0] in_dist,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIST_W-1:0] out_dist,
   output logic [ADDR_W-1:0] out_addr,
   output logic [RANK_W-1:0] out_rank,
   output logic              out_last
`ifdef TOPK_STATS_EN
   ,
   output logic [15:0]       seen_cnt
`endif
);

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   state_t              state_q;
   logic [K-1:0]        vld_q;
   logic [DIST_W-1:0]   dist_q [K];
   logic [ADDR_W-1:0]   addr_q [K];
   logic [RANK_W-1:0]   rd_q;

   logic [K-1:0]        vld_d;
   logic [DIST_W-1:0]   dist_d [K];
   logic [ADDR_W-1:0]   addr_d [K];

   logic [K-1:0]        prec;
   logic                in_hs;
   logic                out_hs;
   logic                rd_at_end;
   logic [RANK_W-1:0]   nxt_idx;
   logic                out_last_c;

   // ------------------------------------------------------------------------
   // Parallel compare: prec[i] is set when the candidate sorts ahead of slot i.
   // Because the bank is sorted and invalid slots sit at the top, prec is a
   // thermometer code: all zeros below the insertion point, all ones from it.
   // ------------------------------------------------------------------------
   always_comb begin
      prec = '0;
      for (int i = 0; i < K; i++) begin
         prec[i] = !vld_q[i]
                || (in_dist <  dist_q[i])
                || ((in_dist == dist_q[i]) && (in_addr < addr_q[i]));
      end
   end

   // Insert-and-shift. A slot whose lower neighbour also lost to the candidate
   // takes that neighbour's contents; the first losing slot takes the
   // candidate. Slot K-1 falls off the end when the bank is full.
   always_comb begin : insert_logic
      int j;
      vld_d = vld_q;
      for (int i = 0; i < K; i++) begin
         j         = (i == 0) ? 0 : i - 1;
         dist_d[i] = dist_q[i];
         addr_d[i] = addr_q[i];
         if (prec[i]) begin
            if ((i != 0) && prec[j]) begin
               vld_d[i]  = vld_q[j];
               dist_d[i] = dist_q[j];
               addr_d[i] = addr_q[j];
            end else begin
               vld_d[i]  = 1'b1;
               dist_d[i] = in_dist;
               addr_d[i] = in_addr;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Drain-side read mux
   // ------------------------------------------------------------------------
   assign rd_at_end  = (rd_q == RANK_W'(K - 1));
   assign nxt_idx    = rd_at_end ? rd_q : rd_q + RANK_W'(1);
   assign out_last_c = rd_at_end || !vld_q[nxt_idx];

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == DRAIN) && vld_q[rd_q];
   assign out_dist  = (state_q == DRAIN) ? dist_q[rd_q] : '0;
   assign out_addr  = (state_q == DRAIN) ? addr_q[rd_q] : '0;
   assign out_rank  = (state_q == DRAIN) ? rd_q : '0;
   assign out_last  = (state_q == DRAIN) && out_last_c;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   // ------------------------------------------------------------------------
   // State machine and slot bank
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= COLLECT;
         vld_q   <= '0;
         rd_q    <= '0;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_hs) begin
                  vld_q <= vld_d;
                  for (int i = 0; i < K; i++) begin
                     dist_q[i] <= dist_d[i];
                     addr_q[i] <= addr_d[i];
                  end
                  if (in_last) begin
                     state_q <= DRAIN;
                     rd_q    <= '0;
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (out_last_c) begin
                     vld_q   <= '0;
                     rd_q    <= '0;
                     state_q <= COLLECT;
                  end else begin
                     rd_q <= rd_q + RANK_W'(1);
                  end
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

`ifdef TOPK_STATS_EN
   // Per-batch accepted-candidate count; frozen during DRAIN because in_ready
   // is low, cleared together with the vld bits at the end of the drain.
   logic [15:0] seen_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         seen_cnt_q <= '0;
      end else if (out_hs && out_last_c) begin
         seen_cnt_q <= '0;
      end else if (in_hs && (seen_cnt_q != 16'hFFFF)) begin
         seen_cnt_q <= seen_cnt_q + 16'd1;
      end
   end

   assign seen_cnt = seen_cnt_q;
`endif

endmodule

// File: tb/tb_topk_stream_sorter.sv
// ---------------------------------------------------------------------------
// Testbench for topk_stream_sorter (K=4, DIST_W=12, ADDR_W=3).
// The reference model sorts each whole batch by (dist, addr) and keeps the
// first K entries; the expected winners go into exp_q and are compared
// against every out handshake. Directed literal checks pin the model and
// cover reset, backpressure, short batches and reset during drain.
// ---------------------------------------------------------------------------
module tb_topk_stream_sorter;
   localparam int DW = 12;
   localparam int AW = 3;
   localparam int KK = 4;
   localparam int RW = 2;
   localparam int EW = 1 + RW + DW + AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_dist = '0;
   logic [AW-1:0] in_addr = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_dist;
   logic [AW-1:0] out_addr;
   logic [RW-1:0] out_rank;
   logic          out_last;
`ifdef TOPK_STATS_EN
   logic [15:0]   seen_cnt;
   int            exp_seen = 0;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [EW-1:0]    exp_q[$];
   logic [DW+AW-1:0] batch_q[$];
   logic [EW-1:0]    exp_e;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   topk_stream_sorter #(.DIST_W(DW), .ADDR_W(AW), .K(KK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dist   (in_dist),
      .in_addr   (in_addr),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dist  (out_dist),
      .out_addr  (out_addr),
      .out_rank  (out_rank),
      .out_last  (out_last)
`ifdef TOPK_STATS_EN
      ,
      .seen_cnt  (seen_cnt)
`endif
   );

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // Stable sort of the whole batch on the {dist, addr} key, keep first K.
   function automatic void model_finish();
      logic [DW+AW-1:0] a[$];
      logic [DW+AW-1:0] t;
      int n;
      a = batch_q;
      for (int i = 0; i < a.size(); i++) begin
         for (int j = 0; j < a.size() - 1 - i; j++) begin
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      n = (a.size() < KK) ? a.size() : KK;
      for (int r = 0; r < n; r++) begin
         exp_q.push_back({(r == n - 1), RW'(r), a[r]});
      end
      batch_q.delete();
   endfunction

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      if (rst && out_valid) begin
         chk("in_ready_low_in_drain", 32'(in_ready), 32'(0));
`ifdef TOPK_STATS_EN
         chk("seen_cnt_hold", 32'(seen_cnt), 32'(exp_seen));
`endif
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_winner: got rank %0d dist %0h addr %0h expected none",
                        out_rank, out_dist, out_addr);
            end else begin
               exp_e = exp_q.pop_front();
               chk("winner", 32'({out_last, out_rank, out_dist, out_addr}), 32'(exp_e));
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic last);
      int t;
      in_valid = 1'b1;
      in_dist  = d;
      in_addr  = a;
      in_last  = last;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         @(posedge clk);
         #1;
         batch_q.push_back({d, a});
`ifdef TOPK_STATS_EN
         if (exp_seen < 16'hFFFF) exp_seen++;
`endif
         if (last) model_finish();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d winners outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      out_ready = 1'b0;
      chk("out_valid_after_drain", 32'(out_valid), 32'(0));
      chk("in_ready_after_drain", 32'(in_ready), 32'(1));
`ifdef TOPK_STATS_EN
      chk("seen_cnt_cleared", 32'(seen_cnt), 32'(0));
      exp_seen = 0;
`endif
   endtask

   task automatic send_basic();
      send(12'd9, 3'd0, 1'b0);
      send(12'd3, 3'd1, 1'b0);
      send(12'd7, 3'd2, 1'b0);
      send(12'd1, 3'd3, 1'b0);
      send(12'd5, 3'd4, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_dist", 32'(out_dist), 32'(0));
      chk("rst_out_addr", 32'(out_addr), 32'(0));
      chk("rst_out_rank", 32'(out_rank), 32'(0));
      chk("rst_out_last", 32'(out_last), 32'(0));
`ifdef TOPK_STATS_EN
      chk("rst_seen_cnt", 32'(seen_cnt), 32'(0));
`endif

      // Basic batch with backpressure at rank 1
      send_basic();
      chk("model_basic_size", 32'(exp_q.size()), 32'(4));
      chk("model_basic_r0", 32'(exp_q[0]), 32'({1'b0, 2'd0, 12'd1, 3'd3}));
      chk("model_basic_r1", 32'(exp_q[1]), 32'({1'b0, 2'd1, 12'd3, 3'd1}));
      chk("model_basic_r2", 32'(exp_q[2]), 32'({1'b0, 2'd2, 12'd5, 3'd4}));
      chk("model_basic_r3", 32'(exp_q[3]), 32'({1'b1, 2'd3, 12'd7, 3'd2}));
      chk("first_out_valid", 32'(out_valid), 32'(1));
      chk("first_in_ready", 32'(in_ready), 32'(0));
`ifdef TOPK_STATS_EN
      chk("basic_seen_cnt", 32'(seen_cnt), 32'(5));
`endif
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(out_valid), 32'(1));
         chk("bp_dist", 32'(out_dist), 32'(3));
         chk("bp_addr", 32'(out_addr), 32'(1));
         chk("bp_rank", 32'(out_rank), 32'(1));
         chk("bp_in_ready", 32'(in_ready), 32'(0));
      end
      drain();

      // Ties: duplicate lands behind the original
      send(12'd5, 3'd6, 1'b0);
      send(12'd5, 3'd2, 1'b0);
      send(12'd5, 3'd4, 1'b0);
      send(12'd5, 3'd2, 1'b1);
      chk("model_ties_r0", 32'(exp_q[0]), 32'({1'b0, 2'd0, 12'd5, 3'd2}));
      chk("model_ties_r1", 32'(exp_q[1]), 32'({1'b0, 2'd1, 12'd5, 3'd2}));
      chk("model_ties_r2", 32'(exp_q[2]), 32'({1'b0, 2'd2, 12'd5, 3'd4}));
      chk("model_ties_r3", 32'(exp_q[3]), 32'({1'b1, 2'd3, 12'd5, 3'd6}));
      drain();

      // Short batch: single max-distance candidate
      send(12'hFFF, 3'd7, 1'b1);
      chk("model_short_size", 32'(exp_q.size()), 32'(1));
      chk("model_short_r0", 32'(exp_q[0]), 32'({1'b1, 2'd0, 12'hFFF, 3'd7}));
      drain();

      // Back-to-back batches of 3 and 2
      send(12'd20, 3'd1, 1'b0);
      send(12'd10, 3'd5, 1'b0);
      send(12'd30, 3'd2, 1'b1);
`ifdef TOPK_STATS_EN
      chk("b3_seen_cnt", 32'(seen_cnt), 32'(3));
`endif
      drain();
      send(12'd8, 3'd3, 1'b0);
      send(12'd8, 3'd0, 1'b1);
`ifdef TOPK_STATS_EN
      chk("b2_seen_cnt", 32'(seen_cnt), 32'(2));
`endif
      drain();

      // Longer batch with evictions, ties and late small entries
      send(12'd100, 3'd0, 1'b0);
      send(12'd50,  3'd1, 1'b0);
      send(12'd75,  3'd2, 1'b0);
      send(12'd50,  3'd0, 1'b0);
      send(12'd200, 3'd3, 1'b0);
      send(12'd10,  3'd4, 1'b0);
      send(12'd75,  3'd1, 1'b0);
      send(12'd0,   3'd7, 1'b1);
      chk("model_long_r3", 32'(exp_q[3]), 32'({1'b1, 2'd3, 12'd50, 3'd1}));
      drain();

      // Reset in mid-drain at rank 2
      send_basic();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("pre_rst_rank", 32'(out_rank), 32'(2));
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      batch_q.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_out_dist", 32'(out_dist), 32'(0));
      chk("mid_rst_out_addr", 32'(out_addr), 32'(0));
      chk("mid_rst_out_rank", 32'(out_rank), 32'(0));
      chk("mid_rst_out_last", 32'(out_last), 32'(0));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
`ifdef TOPK_STATS_EN
      chk("mid_rst_seen_cnt", 32'(seen_cnt), 32'(0));
      exp_seen = 0;
`endif
      send(12'd4, 3'd0, 1'b1);
      chk("post_rst_model", 32'(exp_q[0]), 32'({1'b1, 2'd0, 12'd4, 3'd0}));
      chk("post_rst_last", 32'(out_last), 32'(1));
      drain();

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
